// File: rtl/pong_ball.sv
// Pong ball engine: serve/move/miss sequencing, wall and paddle bounces, scan-cell draw flag.
// Optional feature: define PONG_BALL_SPEEDUP_EN to shorten the movement period on each paddle hit.
//
// state   | meaning
// --------+-------------------------------------------------
// S_SERVE | ball parked at centre, counting serve ticks
// S_MOVE  | ball advances one cell per tick, bounces
// S_MISS  | ball parked on the missed edge until next tick
module pong_ball #(
    parameter int GAME_WIDTH  = 40,
    parameter int GAME_HEIGHT = 30,
    parameter int COORD_W     = 6,
    parameter int SPEED       = 1250000,
    parameter int PADDLE_H    = 6,
    parameter int SERVE_DELAY = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               game_active,
    input  logic [COORD_W-1:0] icolcount,
    input  logic [COORD_W-1:0] irowcount,
    input  logic [COORD_W-1:0] ipaddle_l_y,
    input  logic [COORD_W-1:0] ipaddle_r_y,
    output logic               odrawball,
    output logic [COORD_W-1:0] oballx,
    output logic [COORD_W-1:0] obally,
    output logic               omiss_l,
    output logic               omiss_r,
    output logic [1:0]         ostate
);

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_MOVE  = 2'd1,
        S_MISS  = 2'd2
    } state_t;

    localparam int SCNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

    localparam logic [COORD_W-1:0] X_CTR     = COORD_W'(GAME_WIDTH / 2);
    localparam logic [COORD_W-1:0] Y_CTR     = COORD_W'(GAME_HEIGHT / 2);
    localparam logic [COORD_W-1:0] X_LHIT    = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_LBOUNCE = COORD_W'(2);
    localparam logic [COORD_W-1:0] X_RHIT    = COORD_W'(GAME_WIDTH - 2);
    localparam logic [COORD_W-1:0] X_RBOUNCE = COORD_W'(GAME_WIDTH - 3);
    localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(GAME_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(GAME_HEIGHT - 1);
    localparam logic [COORD_W-1:0] C_ONE     = COORD_W'(1);
    localparam logic [SCNT_W-1:0]  SERVE_CMP = SCNT_W'(SERVE_DELAY - 1);
    localparam logic [31:0]        PERIOD_MAX = 32'(SPEED);

    state_t              state_q, state_d;
    logic [31:0]         tick_cnt_q, tick_cnt_d;
    logic [31:0]         period;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic                dx_q, dx_d, dy_q, dy_d;
    logic [SCNT_W-1:0]   serve_cnt_q, serve_cnt_d;
    logic                miss_l_q, miss_l_d, miss_r_q, miss_r_d;
    logic                draw_q, draw_d;
    logic                tick;

    // One extra bit so a paddle hanging past the bottom edge cannot wrap its range.
    logic [COORD_W:0] y_ext, pl_lo, pl_hi, pr_lo, pr_hi;
    logic             hit_l, hit_r;

    assign y_ext = {1'b0, y_q};
    assign pl_lo = {1'b0, ipaddle_l_y};
    assign pr_lo = {1'b0, ipaddle_r_y};
    assign pl_hi = pl_lo + (COORD_W+1)'(PADDLE_H);
    assign pr_hi = pr_lo + (COORD_W+1)'(PADDLE_H);
    assign hit_l = (y_ext >= pl_lo) && (y_ext < pl_hi);
    assign hit_r = (y_ext >= pr_lo) && (y_ext < pr_hi);

    assign tick = game_active && (tick_cnt_q == period);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        serve_cnt_d = serve_cnt_q;
        miss_l_d    = 1'b0;
        miss_r_d    = 1'b0;
        draw_d      = (icolcount == x_q) && (irowcount == y_q);
        tick_cnt_d  = tick ? 32'd0 : tick_cnt_q + 32'd1;

        if (!game_active) begin
            tick_cnt_d  = 32'd0;
            state_d     = S_SERVE;
            x_d         = X_CTR;
            y_d         = Y_CTR;
            dx_d        = 1'b1;
            dy_d        = 1'b0;
            serve_cnt_d = '0;
        end else if (tick) begin
            case (state_q)
                S_SERVE: begin
                    x_d = X_CTR;
                    y_d = Y_CTR;
                    if (serve_cnt_q == SERVE_CMP) begin
                        state_d     = S_MOVE;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + SCNT_W'(1);
                    end
                end
                S_MOVE: begin
                    if (dy_q && (y_q == Y_MAX)) begin
                        dy_d = 1'b0;
                        y_d  = y_q - C_ONE;
                    end else if (!dy_q && (y_q == '0)) begin
                        dy_d = 1'b1;
                        y_d  = y_q + C_ONE;
                    end else begin
                        y_d = dy_q ? y_q + C_ONE : y_q - C_ONE;
                    end

                    if (!dx_q && (x_q == X_LHIT)) begin
                        if (hit_l) begin
                            dx_d = 1'b1;
                            x_d  = X_LBOUNCE;
                        end else begin
                            x_d      = '0;
                            state_d  = S_MISS;
                            miss_l_d = 1'b1;
                        end
                    end else if (dx_q && (x_q == X_RHIT)) begin
                        if (hit_r) begin
                            dx_d = 1'b0;
                            x_d  = X_RBOUNCE;
                        end else begin
                            x_d      = X_MAX;
                            state_d  = S_MISS;
                            miss_r_d = 1'b1;
                        end
                    end else begin
                        x_d = dx_q ? x_q + C_ONE : x_q - C_ONE;
                    end
                end
                S_MISS: begin
                    // Serve back toward whoever missed: ball at x=0 means the left side.
                    dx_d        = (x_q != '0);
                    x_d         = X_CTR;
                    y_d         = Y_CTR;
                    serve_cnt_d = '0;
                    state_d     = S_SERVE;
                end
                default: begin
                    state_d = S_SERVE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_SERVE;
            tick_cnt_q  <= 32'd0;
            x_q         <= X_CTR;
            y_q         <= Y_CTR;
            dx_q        <= 1'b1;
            dy_q        <= 1'b0;
            serve_cnt_q <= '0;
            miss_l_q    <= 1'b0;
            miss_r_q    <= 1'b0;
            draw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            serve_cnt_q <= serve_cnt_d;
            miss_l_q    <= miss_l_d;
            miss_r_q    <= miss_r_d;
            draw_q      <= draw_d;
        end
    end

`ifdef PONG_BALL_SPEEDUP_EN
    localparam logic [31:0] PERIOD_STEP = 32'(SPEED / 8);
    localparam logic [31:0] PERIOD_MIN  = 32'(SPEED / 4);

    logic [31:0] period_q, period_d;
    logic        paddle_hit;

    assign period     = period_q;
    assign paddle_hit = tick && (state_q == S_MOVE) &&
                        ((!dx_q && (x_q == X_LHIT) && hit_l) ||
                         ( dx_q && (x_q == X_RHIT) && hit_r));

    // Holding full period throughout SERVE covers every way of entering it.
    always_comb begin
        period_d = period_q;
        if (state_d == S_SERVE) begin
            period_d = PERIOD_MAX;
        end else if (paddle_hit) begin
            period_d = (period_q >= PERIOD_MIN + PERIOD_STEP) ? period_q - PERIOD_STEP
                                                              : PERIOD_MIN;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            period_q <= PERIOD_MAX;
        end else begin
            period_q <= period_d;
        end
    end
`else
    assign period = PERIOD_MAX;
`endif

    assign oballx    = x_q;
    assign obally    = y_q;
    assign omiss_l   = miss_l_q;
    assign omiss_r   = miss_r_q;
    assign odrawball = draw_q;
    assign ostate    = state_q;

endmodule
